// File: rtl/instr_fetch_unit.sv
// Instruction fetch: req/ack memory fetch, small FIFO, field decode, redirect and halt.
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_stall counters.
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       QDEPTH   = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [5:0]        opcode,
   output logic [8:0]        xoxo,
   output logic [9:0]        xox,
   output logic [1:0]        xods,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall
`endif
);

   localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CW = $clog2(QDEPTH) + 1;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt, tgt, tgt_nxt, redir_addr;
   logic              req_c, push, pop, room, stall;

   logic [31:0]       q_word [QDEPTH];
   logic [ADDR_W-1:0] q_pc   [QDEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count;

   assign redir_addr = redirect_pc & ~ADDR_W'(3);
   assign out_valid  = (count != '0);
   assign pop        = out_valid && out_ready;
   // A pop in the same cycle frees a slot for the word about to be requested.
   assign room       = (count < CW'(QDEPTH)) || pop;

   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_c     = 1'b0;
      push      = 1'b0;
      pc_nxt    = pc;
      tgt_nxt   = tgt;
      stall     = 1'b0;
      case (state)
         FETCH: begin
            stall = halt || !room;
            if (redirect_valid) begin
               pc_nxt = redir_addr;
            end else if (!halt && room) begin
               req_c     = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            req_c = 1'b1;
            if (imem_ack) begin
               state_nxt = FETCH;
               if (redirect_valid) begin
                  pc_nxt = redir_addr;
               end else begin
                  push   = 1'b1;
                  pc_nxt = pc + ADDR_W'(4);
               end
            end else if (redirect_valid) begin
               tgt_nxt   = redir_addr;
               state_nxt = DISCARD;
            end
         end
         DISCARD: begin
            // Old request stays on the bus until acked; a newer redirect wins.
            req_c = 1'b1;
            if (redirect_valid) tgt_nxt = redir_addr;
            if (imem_ack) begin
               state_nxt = FETCH;
               pc_nxt    = tgt_nxt;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   assign imem_req  = req_c && !rst;
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc  <= RESET_PC;
         tgt <= RESET_PC;
      end else begin
         pc  <= pc_nxt;
         tgt <= tgt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_word[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]   <= pc;
      end
   end

   always_comb begin
      out_pc = '0;
      opcode = '0;
      xoxo   = '0;
      xox    = '0;
      xods   = '0;
      if (out_valid) begin
         out_pc = q_pc[rd_ptr];
         opcode = q_word[rd_ptr][31:26];
         if (opcode == 6'd31) begin
            xoxo = q_word[rd_ptr][9:1];
            xox  = q_word[rd_ptr][10:1];
         end
         if (opcode == 6'd58 || opcode == 6'd62) xods = q_word[rd_ptr][1:0];
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (push && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
         if (stall && perf_stall != '1)  perf_stall   <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: transaction-level stream model plus directed scenarios.
// Also checks the perf counters when FETCH_PERF_CNT_EN is defined.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0;
   localparam int          QD     = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [5:0]  opcode;
   logic [8:0]  xoxo;
   logic [9:0]  xox;
   logic [1:0]  xods;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall;
`endif

   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC), .QDEPTH(QD)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .xoxo(xoxo), .xox(xox), .xods(xods),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int unsigned checks = 0, passed = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   logic [31:0] mem [256];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem[a[9:2]];
   endfunction

   function automatic logic [26:0] ref_fields(input logic [31:0] w);
      logic [5:0] op;
      op = w[31:26];
      return {op,
              (op == 6'd31) ? w[9:1]  : 9'd0,
              (op == 6'd31) ? w[10:1] : 10'd0,
              (op == 6'd58 || op == 6'd62) ? w[1:0] : 2'd0};
   endfunction

   // staged stimulus, applied at the next falling edge
   logic        s_rst = 1'b1, s_ready = 1'b0, s_halt = 1'b0, s_redir = 1'b0, s_spur_ack = 1'b0;
   logic [31:0] s_rpc = '0;
   logic        lat_rand = 1'b0;
   int unsigned lat_fix = 1, lat = 1;
   int          req_cnt = 0;

   // reference model of the architectural stream
   int          occ = 0;
   logic [31:0] exp_pc = RST_PC, fetch_pc = RST_PC, held_addr = '0, last_issue_addr = '0;
   logic        outstanding = 1'b0, poisoned = 1'b0, prev_rst = 1'b0;
   int unsigned issues = 0, acks = 0, txn_len = 0, last_txn_len = 0;
   logic [31:0] m_fetched = '0, m_stall = '0;

   task automatic step();
      logic pop, room, spur;
      logic [31:0] tgt;
      @(negedge clk);
      rst            = s_rst;
      out_ready      = s_ready;
      halt           = s_halt;
      redirect_valid = s_redir;
      redirect_pc    = s_rpc;
      spur           = s_spur_ack;
      s_redir        = 1'b0;
      s_spur_ack     = 1'b0;
      #1;
      if (imem_req && req_cnt == 0) lat = lat_rand ? $urandom_range(1, 4) : lat_fix;
      if (imem_req && req_cnt >= int'(lat)) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_word(imem_addr);
      end else begin
         imem_ack   = spur && !imem_req;
         imem_rdata = $urandom;
      end
      #1;
      if (rst) begin
         check("rst_req", imem_req, 0);
         if (prev_rst) check("rst_valid", out_valid, 0);
         occ = 0; exp_pc = RST_PC; fetch_pc = RST_PC;
         outstanding = 0; poisoned = 0; m_fetched = '0; m_stall = '0;
         prev_rst = 1'b1;
      end else begin
         prev_rst = 1'b0;
`ifdef FETCH_PERF_CNT_EN
         check("perf_fetched", perf_fetched, m_fetched);
         check("perf_stall", perf_stall, m_stall);
`endif
         pop = out_valid && out_ready;
         check("valid", out_valid, occ > 0);
         if (occ > 0) begin
            check("out_pc", out_pc, exp_pc);
            check("fields", {opcode, xoxo, xox, xods}, ref_fields(mem_word(exp_pc)));
         end else begin
            check("idle_outputs", {out_pc, opcode, xoxo, xox, xods}, 0);
         end
         room = (occ < QD) || pop;
         if (outstanding) begin
            check("req_held", imem_req, 1);
            check("addr_held", imem_addr, held_addr);
            txn_len++;
         end else begin
            check("req", imem_req, !halt && !redirect_valid && room);
            if (halt || !room) m_stall++;
            if (imem_req) begin
               check("issue_addr", imem_addr, fetch_pc);
               issues++; last_issue_addr = imem_addr; held_addr = imem_addr; txn_len = 1;
            end
         end
         if (redirect_valid) begin
            tgt = redirect_pc & ~32'd3;
            occ = 0; exp_pc = tgt; fetch_pc = tgt;
            if (outstanding) begin
               if (imem_ack) begin
                  outstanding = 0; poisoned = 0; last_txn_len = txn_len; acks++;
               end else begin
                  poisoned = 1;
               end
            end
         end else begin
            if (pop) begin occ--; exp_pc += 32'd4; end
            if (outstanding && imem_ack) begin
               if (!poisoned) begin
                  check("push_when_full", occ >= QD, 0);
                  occ++; fetch_pc += 32'd4; m_fetched++;
               end
               outstanding = 0; poisoned = 0; last_txn_len = txn_len; acks++;
            end else if (!outstanding && imem_req) begin
               outstanding = 1;
            end
         end
      end
      req_cnt = (imem_ack || !imem_req) ? 0 : req_cnt + 1;
   endtask

   task automatic do_reset();
      s_rst = 1'b1;
      repeat (2) step();
      s_rst = 1'b0;
   endtask

   int unsigned i0, f0, a0, seen;
   int n;

   initial begin
      for (int i = 0; i < 256; i++) begin
         logic [31:0] w;
         w = $urandom;
         case ($urandom_range(0, 4))
            0: w[31:26] = 6'd31;
            1: w[31:26] = 6'd58;
            2: w[31:26] = 6'd62;
            3: w[31:26] = 6'd14;
            default: ;
         endcase
         mem[i] = w;
      end
      mem[0] = 32'h7C22_1A14;
      mem[1] = 32'h3821_0005;
      mem[2] = 32'hE823_0002;

      // zero-wait memory, consumer always ready
      lat_fix = 1;
      s_ready = 1'b1;
      do_reset();
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid && out_pc == 32'h0) begin
            seen++;
            check("e0_opcode", opcode, 31); check("e0_xoxo", xoxo, 266);
            check("e0_xox", xox, 266);      check("e0_xods", xods, 0);
         end
         if (out_valid && out_pc == 32'h4) begin
            seen++;
            check("e1_opcode", opcode, 14); check("e1_xoxo", xoxo, 0);
            check("e1_xox", xox, 0);        check("e1_xods", xods, 0);
         end
         if (out_valid && out_pc == 32'h8) begin
            seen++;
            check("e2_opcode", opcode, 58); check("e2_xods", xods, 2);
         end
      end
      check("e012_seen", seen, 3);

      // consumer stalled: exactly QDEPTH requests, then resume at 0x8
      s_ready = 1'b0;
      do_reset();
      i0 = issues;
      repeat (10) step();
      check("stall_issue_count", issues - i0, QD);
      check("stall_req_low", imem_req, 0);
      s_ready = 1'b1;
      i0 = issues; n = 0;
      while (issues == i0 && n < 10) begin step(); n++; end
      check("resume_wait", n < 10, 1);
      check("resume_addr", last_issue_addr, 32'h8);
      repeat (8) step();

      // ack delayed 3 cycles
      lat_fix = 3;
      do_reset();
      a0 = acks; f0 = m_fetched; n = 0;
      while (acks == a0 && n < 30) begin step(); n++; end
      check("delay_wait", n < 30, 1);
      check("delay_req_cycles", last_txn_len, 4);
      check("delay_one_push", m_fetched - f0, 1);

      // redirect to 0x100 while waiting on 0x10
      do_reset();
      n = 0;
      while (!(outstanding && last_issue_addr == 32'h10 && txn_len == 1) && n < 100) begin step(); n++; end
      check("wait_issue_0x10", n < 100, 1);
      step();
      s_redir = 1'b1; s_rpc = 32'h100;
      step();
      step();
      check("redir_flush", out_valid, 0);
      i0 = issues; n = 0;
      while (issues == i0 && n < 20) begin step(); n++; end
      check("redir_issue_wait", n < 20, 1);
      check("redir_issue_addr", last_issue_addr, 32'h100);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      check("redir_out_wait", n < 20, 1);
      check("redir_first_pc", out_pc, 32'h100);

      // halt while a request is outstanding
      i0 = issues; n = 0;
      while (issues == i0 && n < 40) begin step(); n++; end
      check("halt_issue_wait", n < 40, 1);
      s_halt = 1'b1;
      i0 = issues; f0 = m_fetched;
      repeat (10) step();
      check("halt_no_new_req", issues - i0, 0);
      check("halt_word_delivered", m_fetched - f0, 1);
      s_halt = 1'b0;
      repeat (6) step();

      // reset while waiting with a non-empty FIFO, then a stray ack
      s_ready = 1'b0;
      do_reset();
      n = 0;
      while (!(occ == 1 && outstanding) && n < 40) begin step(); n++; end
      check("rst_setup_wait", n < 40, 1);
      s_rst = 1'b1;
      step();
      s_spur_ack = 1'b1;
      step();
      check("rst_clears_valid", out_valid, 0);
      check("rst_req_low", imem_req, 0);
      s_rst = 1'b0; s_halt = 1'b1; s_spur_ack = 1'b1;
      step();
      s_halt = 1'b0; s_ready = 1'b1;
      i0 = issues;
      step();
      check("late_ack_ignored", out_valid, 0);
      check("post_rst_issue", issues - i0, 1);
      check("post_rst_addr", imem_addr, RST_PC);

      // randomized traffic, redirects (including near address wrap) and halts
      lat_rand = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         s_ready = ($urandom_range(0, 3) != 0);
         s_halt  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 11) == 0) begin
            s_redir = 1'b1;
            s_rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                  : ($urandom & 32'h3FF);
         end
         step();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
